// File: rtl/gcd_arbiter_if.sv
// Requester, engine and response signal bundle for gcd_arbiter.
// slave is the arbiter's view; master is the view of the surrounding logic.
interface gcd_arbiter_if #(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned WIDTH = 8,
  parameter int unsigned ID_W  = 2
);
  logic [N_REQ-1:0]       req_valid_i;
  logic [N_REQ-1:0]       req_ready_o;
  logic [N_REQ*WIDTH-1:0] req_a_i;
  logic [N_REQ*WIDTH-1:0] req_b_i;
  logic                   eng_valid_o;
  logic [WIDTH-1:0]       eng_a_o;
  logic [WIDTH-1:0]       eng_b_o;
  logic [WIDTH-1:0]       eng_gcd_i;
  logic                   eng_valid_i;
  logic                   rsp_valid_o;
  logic                   rsp_ready_i;
  logic [ID_W-1:0]        rsp_id_o;
  logic [WIDTH-1:0]       rsp_gcd_o;
  logic                   busy_o;
  logic                   err_o;

  modport slave (
    input  req_valid_i, req_a_i, req_b_i, eng_gcd_i, eng_valid_i, rsp_ready_i,
    output req_ready_o, eng_valid_o, eng_a_o, eng_b_o, rsp_valid_o, rsp_id_o,
           rsp_gcd_o, busy_o, err_o
  );

  modport master (
    output req_valid_i, req_a_i, req_b_i, eng_gcd_i, eng_valid_i, rsp_ready_i,
    input  req_ready_o, eng_valid_o, eng_a_o, eng_b_o, rsp_valid_o, rsp_id_o,
           rsp_gcd_o, busy_o, err_o
  );
endinterface

// File: rtl/gcd_arbiter.sv
// Round-robin arbiter sharing one GCD engine among N_REQ requesters, one job in flight.
// Define GCD_ARB_BYPASS_EN to answer trivial jobs (zero or equal operands) without the engine.
module gcd_arbiter #(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned WIDTH = 8,
  parameter int unsigned ID_W  = 2
) (
  input  logic         clk_i,
  input  logic         rst_i,
  gcd_arbiter_if.slave bus
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_RESP  = 2'd3;

  logic [1:0]       state_q, state_d;
  logic [ID_W-1:0]  rr_last_q, rr_last_d;
  logic [ID_W-1:0]  id_q, id_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, gcd_q, gcd_d;
  logic             eng_valid_q, eng_valid_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic             busy_q, busy_d;
  logic             err_q, err_d;

  logic [WIDTH-1:0] a_arr [N_REQ];
  logic [WIDTH-1:0] b_arr [N_REQ];
  logic [WIDTH-1:0] sel_a, sel_b;
  logic [ID_W-1:0]  grant_idx;
  logic             grant_found;
  logic             accept;
  logic             bypass;

  for (genvar k = 0; k < N_REQ; k++) begin : g_unpack
    assign a_arr[k] = bus.req_a_i[k*WIDTH +: WIDTH];
    assign b_arr[k] = bus.req_b_i[k*WIDTH +: WIDTH];
  end

  // Round-robin search: indices above rr_last first, then wrap to the rest.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      if (!grant_found && bus.req_valid_i[k] && (k > 32'(rr_last_q))) begin
        grant_found = 1'b1;
        grant_idx   = ID_W'(k);
      end
    end
    for (int unsigned k = 0; k < N_REQ; k++) begin
      if (!grant_found && bus.req_valid_i[k] && (k <= 32'(rr_last_q))) begin
        grant_found = 1'b1;
        grant_idx   = ID_W'(k);
      end
    end
  end

  assign sel_a  = a_arr[grant_idx];
  assign sel_b  = b_arr[grant_idx];
  assign accept = (state_q == S_IDLE) && grant_found;

`ifdef GCD_ARB_BYPASS_EN
  assign bypass = (sel_a == '0) || (sel_b == '0) || (sel_a == sel_b);
`else
  assign bypass = 1'b0;
`endif

  // Grant is combinational so the requester sees it in the same IDLE cycle; forced low in reset.
  assign bus.req_ready_o = (accept && rst_i) ? (N_REQ'(1) << grant_idx) : '0;

  always_comb begin
    state_d     = state_q;
    rr_last_d   = rr_last_q;
    id_d        = id_q;
    a_d         = a_q;
    b_d         = b_q;
    gcd_d       = gcd_q;
    eng_valid_d = 1'b0;
    rsp_valid_d = rsp_valid_q;
    err_d       = err_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          rr_last_d = grant_idx;
          id_d      = grant_idx;
          a_d       = sel_a;
          b_d       = sel_b;
          if (bypass) begin
            state_d     = S_RESP;
            rsp_valid_d = 1'b1;
            gcd_d       = (sel_a == '0) ? sel_b : sel_a;
          end else begin
            state_d     = S_ISSUE;
            eng_valid_d = 1'b1;
          end
        end
      end
      S_ISSUE: state_d = S_WAIT;
      S_WAIT: begin
        if (bus.eng_valid_i) begin
          gcd_d       = bus.eng_gcd_i;
          rsp_valid_d = 1'b1;
          state_d     = S_RESP;
        end
      end
      S_RESP: begin
        if (bus.rsp_ready_i) begin
          rsp_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (bus.eng_valid_i && (state_q != S_WAIT)) err_d = 1'b1;
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q     <= S_IDLE;
      rr_last_q   <= ID_W'(N_REQ - 1);
      id_q        <= '0;
      a_q         <= '0;
      b_q         <= '0;
      gcd_q       <= '0;
      eng_valid_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_last_q   <= rr_last_d;
      id_q        <= id_d;
      a_q         <= a_d;
      b_q         <= b_d;
      gcd_q       <= gcd_d;
      eng_valid_q <= eng_valid_d;
      rsp_valid_q <= rsp_valid_d;
      busy_q      <= busy_d;
      err_q       <= err_d;
    end
  end

  assign bus.eng_valid_o = eng_valid_q;
  assign bus.eng_a_o     = a_q;
  assign bus.eng_b_o     = b_q;
  assign bus.rsp_valid_o = rsp_valid_q;
  assign bus.rsp_id_o    = id_q;
  assign bus.rsp_gcd_o   = gcd_q;
  assign bus.busy_o      = busy_q;
  assign bus.err_o       = err_q;

endmodule

// File: tb/tb_gcd_arbiter.sv
// Bench for gcd_arbiter: directed requester jobs, a fixed-latency engine stand-in,
// and a per-cycle transaction-level model of grants, engine starts and responses.
module tb_gcd_arbiter;
  localparam int N  = 4;
  localparam int W  = 8;
  localparam int IW = 2;
  localparam int L  = 3;

  logic clk;
  logic rst_n;

  gcd_arbiter_if #(.N_REQ(N), .WIDTH(W), .ID_W(IW)) bus ();
  gcd_arbiter #(.N_REQ(N), .WIDTH(W), .ID_W(IW)) dut (.clk_i(clk), .rst_i(rst_n), .bus(bus));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input bit ok, input string name, input int act, input int exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int gcd_f(input int a, input int b);
    int x, y, t;
    x = a; y = b;
    while (y != 0) begin t = x % y; x = y; y = t; end
    return x;
  endfunction

  // First valid requester after 'last', wrapping; -1 if none.
  function automatic int pick(input logic [N-1:0] v, input int last);
    for (int i = 1; i <= N; i++) begin
      int k;
      k = (last + i) % N;
      if (((v >> k) & 4'b0001) != 4'b0000) return k;
    end
    return -1;
  endfunction

  function automatic bit is_bypass(input int a, input int b);
`ifdef GCD_ARB_BYPASS_EN
    return (a == 0) || (b == 0) || (a == b);
`else
    return (a < 0) && (b < 0);
`endif
  endfunction

  int opa [N];
  int opb [N];
  logic [N-1:0] oneshot;
  bit spur;
  bit pend;
  int cnt, ea, eb;

  // Model state and logs
  int m_rr, ncyc, last_acc;
  bit m_busy, m_issue, m_wait, m_resp, m_err, prev_rsp;
  int eng_qa[$], eng_qb[$], rsp_qid[$], rsp_qg[$];
  int start_a[$], start_b[$], log_id[$], log_g[$], lat_log[$];

  always @(negedge clk) begin : cmp
    logic [N-1:0] er;
    int g, a, b;
    bit n_busy, n_issue, n_wait, n_resp, n_err, z;
    if (!rst_n) begin
      z = (bus.req_ready_o == '0) && !bus.eng_valid_o && (bus.eng_a_o == '0) &&
          (bus.eng_b_o == '0) && !bus.rsp_valid_o && (bus.rsp_id_o == '0) &&
          (bus.rsp_gcd_o == '0) && !bus.busy_o && !bus.err_o;
      chk(z, "reset_outputs", 32'(z), 1);
      m_rr = N - 1; m_busy = 0; m_issue = 0; m_wait = 0; m_resp = 0; m_err = 0;
      prev_rsp = 0;
      eng_qa.delete(); eng_qb.delete(); rsp_qid.delete(); rsp_qg.delete();
    end else begin
      ncyc++;
      er = '0;
      g  = -1;
      if (!m_busy) g = pick(bus.req_valid_i, m_rr);
      if (g >= 0) er = 4'b0001 << g;
      chk(bus.req_ready_o == er, "req_ready", 32'(bus.req_ready_o), 32'(er));
      chk(bus.busy_o == m_busy, "busy", 32'(bus.busy_o), 32'(m_busy));
      chk(bus.err_o == m_err, "err", 32'(bus.err_o), 32'(m_err));
      chk(bus.rsp_valid_o == m_resp, "rsp_valid", 32'(bus.rsp_valid_o), 32'(m_resp));
      chk(bus.eng_valid_o == m_issue, "eng_valid", 32'(bus.eng_valid_o), 32'(m_issue));
      if (bus.eng_valid_o && eng_qa.size() > 0) begin
        chk(32'(bus.eng_a_o) == eng_qa[0], "eng_a", 32'(bus.eng_a_o), eng_qa[0]);
        chk(32'(bus.eng_b_o) == eng_qb[0], "eng_b", 32'(bus.eng_b_o), eng_qb[0]);
        start_a.push_back(32'(bus.eng_a_o));
        start_b.push_back(32'(bus.eng_b_o));
        void'(eng_qa.pop_front());
        void'(eng_qb.pop_front());
      end
      if (bus.rsp_valid_o && rsp_qid.size() > 0) begin
        chk(32'(bus.rsp_id_o) == rsp_qid[0], "rsp_id", 32'(bus.rsp_id_o), rsp_qid[0]);
        chk(32'(bus.rsp_gcd_o) == rsp_qg[0], "rsp_gcd", 32'(bus.rsp_gcd_o), rsp_qg[0]);
        if (!prev_rsp) lat_log.push_back(ncyc - last_acc);
        if (bus.rsp_ready_i) begin
          log_id.push_back(32'(bus.rsp_id_o));
          log_g.push_back(32'(bus.rsp_gcd_o));
          void'(rsp_qid.pop_front());
          void'(rsp_qg.pop_front());
        end
      end
      prev_rsp = bus.rsp_valid_o && !bus.rsp_ready_i;

      n_busy = m_busy; n_issue = 1'b0; n_wait = m_wait; n_resp = m_resp; n_err = m_err;
      if (g >= 0) begin
        a = opa[g]; b = opb[g];
        last_acc = ncyc;
        m_rr = g;
        n_busy = 1'b1;
        rsp_qid.push_back(g);
        rsp_qg.push_back(gcd_f(a, b));
        if (is_bypass(a, b)) n_resp = 1'b1;
        else begin
          n_issue = 1'b1;
          eng_qa.push_back(a);
          eng_qb.push_back(b);
        end
      end
      if (m_issue) n_wait = 1'b1;
      if (bus.eng_valid_i) begin
        if (m_wait) begin n_wait = 1'b0; n_resp = 1'b1; end
        else n_err = 1'b1;
      end
      if (m_resp && bus.rsp_ready_i) begin n_resp = 1'b0; n_busy = 1'b0; end
      m_busy = n_busy; m_issue = n_issue; m_wait = n_wait; m_resp = n_resp; m_err = n_err;
    end
  end

  task automatic drive_ops();
    bus.req_a_i = {8'(opa[3]), 8'(opa[2]), 8'(opa[1]), 8'(opa[0])};
    bus.req_b_i = {8'(opb[3]), 8'(opb[2]), 8'(opb[1]), 8'(opb[0])};
  endtask

  task automatic set_req(input int k, input int a, input int b);
    opa[k] = a;
    opb[k] = b;
    drive_ops();
    bus.req_valid_i = bus.req_valid_i | (4'b0001 << k);
  endtask

  // One clock: retire accepted one-shot requests and run the latency-L engine stand-in.
  task automatic tick();
    logic [N-1:0] acc;
    bit st;
    int sa, sb;
    @(negedge clk);
    acc = bus.req_valid_i & bus.req_ready_o;
    st  = bus.eng_valid_o;
    sa  = 32'(bus.eng_a_o);
    sb  = 32'(bus.eng_b_o);
    @(posedge clk);
    #1;
    bus.req_valid_i = bus.req_valid_i & ~(acc & oneshot);
    bus.eng_valid_i = 1'b0;
    if (!rst_n) pend = 1'b0;
    else begin
      if (st) begin pend = 1'b1; cnt = L; ea = sa; eb = sb; end
      if (pend) begin
        cnt--;
        if (cnt == 0) begin
          pend = 1'b0;
          bus.eng_valid_i = 1'b1;
          bus.eng_gcd_i   = 8'(gcd_f(ea, eb));
        end
      end
      if (spur) begin
        spur = 1'b0;
        bus.eng_valid_i = 1'b1;
        bus.eng_gcd_i   = 8'hAA;
      end
    end
  endtask

  task automatic wait_log(input int n, input string name);
    int budget;
    budget = 300;
    while (log_id.size() < n && budget > 0) begin tick(); budget--; end
    chk(log_id.size() >= n, name, log_id.size(), n);
  endtask

  task automatic wait_rsp_valid(input string name);
    int budget;
    budget = 300;
    while (!bus.rsp_valid_o && budget > 0) begin tick(); budget--; end
    chk(bus.rsp_valid_o, name, 32'(bus.rsp_valid_o), 1);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: got 1 expected 0");
    $fatal(1);
  end

  int t2_id [5] = '{0, 1, 2, 3, 0};
  int t2_g  [5] = '{4, 3, 7, 1, 4};

  initial begin
    int base, ns, budget;
    bit z;
    rst_n = 1'b0;
    bus.req_valid_i = '0;
    bus.rsp_ready_i = 1'b1;
    bus.eng_valid_i = 1'b0;
    bus.eng_gcd_i   = '0;
    for (int i = 0; i < N; i++) begin opa[i] = 0; opb[i] = 0; end
    drive_ops();
    oneshot = '1;
    spur = 1'b0; pend = 1'b0; cnt = 0; ea = 0; eb = 0;
    repeat (3) tick();
    chk(!bus.busy_o && !bus.rsp_valid_o && !bus.eng_valid_o, "reset_idle", 32'(bus.busy_o), 0);
    rst_n = 1'b1;
    tick();

    // All four requesters held valid: grants 0,1,2,3,0.
    oneshot = '0;
    set_req(0, 12, 8); set_req(1, 9, 6); set_req(2, 35, 14); set_req(3, 17, 5);
    wait_log(5, "t2_done");
    bus.req_valid_i = '0;
    oneshot = '1;
    for (int i = 0; i < 5; i++) begin
      chk(log_id[i] == t2_id[i], "t2_id", log_id[i], t2_id[i]);
      chk(log_g[i] == t2_g[i], "t2_gcd", log_g[i], t2_g[i]);
    end
    tick();

    // Single requester 0, gcd(48,18)=6.
    base = log_id.size();
    ns   = start_a.size();
    set_req(0, 48, 18);
    wait_log(base + 1, "t1_done");
    chk(log_id[base] == 0, "t1_id", log_id[base], 0);
    chk(log_g[base] == 6, "t1_gcd", log_g[base], 6);
    chk(start_a.size() == ns + 1, "t1_eng_starts", start_a.size(), ns + 1);
    chk(start_a[ns] == 48 && start_b[ns] == 18, "t1_eng_ops", start_a[ns], 48);
    chk(lat_log[base] == 2 + L, "t1_latency", lat_log[base], 2 + L);
    chk(!bus.busy_o, "t1_busy_low", 32'(bus.busy_o), 0);
    tick();

    // Backpressure on (100,75): response held 10 cycles, requester 2 kept waiting.
    base = log_id.size();
    bus.rsp_ready_i = 1'b0;
    set_req(1, 100, 75);
    wait_rsp_valid("t3_rsp_valid");
    set_req(2, 21, 14);
    repeat (10) begin
      chk(bus.rsp_valid_o && bus.rsp_gcd_o == 8'd25 && bus.rsp_id_o == 2'd1, "t3_hold",
          32'(bus.rsp_gcd_o), 25);
      chk(bus.req_ready_o == '0, "t3_no_grant", 32'(bus.req_ready_o), 0);
      tick();
    end
    bus.rsp_ready_i = 1'b1;
    wait_log(base + 2, "t3_done");
    chk(log_id[base] == 1 && log_g[base] == 25, "t3_first", log_g[base], 25);
    chk(log_id[base + 1] == 2 && log_g[base + 1] == 7, "t3_second", log_g[base + 1], 7);
    tick();

    // Reset while the engine is working on (200,150).
    set_req(3, 200, 150);
    budget = 50;
    while (!bus.eng_valid_o && budget > 0) begin tick(); budget--; end
    chk(bus.eng_valid_o, "t4_started", 32'(bus.eng_valid_o), 1);
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    z = (bus.req_ready_o == '0) && !bus.eng_valid_o && (bus.eng_a_o == '0) &&
        (bus.eng_b_o == '0) && !bus.rsp_valid_o && (bus.rsp_id_o == '0) &&
        (bus.rsp_gcd_o == '0) && !bus.busy_o && !bus.err_o;
    chk(z, "t4_reset_now", 32'(z), 1);
    tick(); tick();
    rst_n = 1'b1;
    base = log_id.size();
    set_req(0, 200, 150);
    set_req(3, 200, 150);
    wait_log(base + 2, "t4_done");
    chk(log_id[base] == 0 && log_g[base] == 50, "t4_req0_first", log_id[base], 0);
    chk(log_id[base + 1] == 3 && log_g[base + 1] == 50, "t4_req3_next", log_id[base + 1], 3);
    tick();

    // Spurious engine valid while idle.
    base = log_id.size();
    spur = 1'b1;
    repeat (3) tick();
    chk(bus.err_o, "t5_err_set", 32'(bus.err_o), 1);
    repeat (3) tick();
    chk(bus.err_o, "t5_err_sticky", 32'(bus.err_o), 1);
    chk(log_id.size() == base && !bus.rsp_valid_o, "t5_no_rsp", log_id.size(), base);

    // Trivial operands: bypassed when the feature is built in, otherwise sent to the engine.
    base = log_id.size();
    ns   = start_a.size();
    set_req(0, 0, 42);
    wait_log(base + 1, "t6_first");
    set_req(1, 9, 9);
    wait_log(base + 2, "t6_second");
    chk(log_id[base] == 0 && log_g[base] == 42, "t6_gcd_0_42", log_g[base], 42);
    chk(log_id[base + 1] == 1 && log_g[base + 1] == 9, "t6_gcd_9_9", log_g[base + 1], 9);
`ifdef GCD_ARB_BYPASS_EN
    chk(start_a.size() == ns, "t6_no_engine", start_a.size(), ns);
    chk(lat_log[base] == 1, "t6_lat_first", lat_log[base], 1);
    chk(lat_log[base + 1] == 1, "t6_lat_second", lat_log[base + 1], 1);
`else
    chk(start_a.size() == ns + 2, "t6_engine_used", start_a.size(), ns + 2);
    chk(start_a[ns] == 0 && start_b[ns] == 42, "t6_eng_ops", start_b[ns], 42);
    chk(lat_log[base] == 2 + L, "t6_lat_first", lat_log[base], 2 + L);
`endif
    tick();

    chk(rsp_qid.size() == 0 && eng_qa.size() == 0, "final_queues_empty", rsp_qid.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
